// File: rtl/command_pkg.sv
// Shared opcodes, response codes, register indices and parser state for the
// UART command register file.
package command_pkg;

  localparam logic [7:0] CMD_PING     = 8'h01;
  localparam logic [7:0] CMD_READ     = 8'h02;
  localparam logic [7:0] CMD_WRITE    = 8'h03;
  localparam logic [7:0] CMD_ARM      = 8'h04;
  localparam logic [7:0] CMD_DISARM   = 8'h05;
  localparam logic [7:0] CMD_READ_ALL = 8'h06;
  localparam logic [7:0] CMD_STATUS   = 8'h07;

  localparam logic [7:0] RESP_ACK  = 8'hAA;
  localparam logic [7:0] RESP_NACK = 8'hFF;

  localparam int REG_CLKEDGES   = 0;
  localparam int REG_IOEDGES    = 1;
  localparam int REG_NSEDGES    = 2;
  localparam int REG_PULSEWIDTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAITPARAM = 2'd1,
    ST_WAITDATA  = 2'd2,
    ST_STREAM    = 2'd3
  } parser_state_t;

  function automatic logic [7:0] status_byte(input logic armed, input logic ovf,
                                             input logic rx_ovr);
    return {armed, ovf, rx_ovr, 5'b0_0000};
  endfunction

endpackage

// File: rtl/command_regfile_resp_fifo.sv
// Show-ahead byte FIFO for response bytes; the head is always visible and a
// push into a full FIFO is only accepted when a pop happens in the same cycle.
module resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign ovf     = push && full && !do_pop;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/command_regfile.sv
// Host command parser owning the glitch-timing register bank, the arm flag and
// the response byte stream toward the UART transmitter.
module command_regfile
  import command_pkg::*;
#(
  parameter int NUM_REGS       = 4,
  parameter int REG_BYTES      = 4,
  parameter int RESP_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rx_valid,
  input  logic [7:0]                      rx_byte,
  input  logic                            tx_ready,
  output logic                            tx_valid,
  output logic [7:0]                      tx_byte,
  output logic                            armed,
  output logic [NUM_REGS*REG_BYTES*8-1:0] regs_flat
);

  localparam int RIW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int BIW = (REG_BYTES > 1) ? $clog2(REG_BYTES) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES) + 1;

  parser_state_t  state_q, state_d;
  logic [7:0]     opcode_q, opcode_d;
  logic [7:0]     param_q, param_d;
  logic [RIW-1:0] sel_q, sel_d;
  logic [BIW-1:0] bcnt_q, bcnt_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           armed_q, armed_d;
  logic           ovf_q, ovf_d;
  logic           rx_ovr_q, rx_ovr_d;
  logic [7:0]     regs_q [NUM_REGS][REG_BYTES];
  logic [7:0]     regs_d [NUM_REGS][REG_BYTES];

  logic           push;
  logic [7:0]     push_data;
  logic           status_clr;
  logic           fifo_empty;
  logic           fifo_full;
  logic           fifo_ovf;
  logic           waiting;
  logic           tmo_expired;
  logic           rd_ok;
  logic           wr_ok;

  resp_fifo #(
    .WIDTH (8),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (tx_ready),
    .head      (tx_byte),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .ovf       (fifo_ovf)
  );

  assign tx_valid = !fifo_empty;
  assign armed    = armed_q;

  // Register/byte fields are compared one bit wider so NUM_REGS or REG_BYTES of 16 still work.
  assign rd_ok = (param_q < 8'(NUM_REGS)) && (rx_byte < 8'(REG_BYTES));
  assign wr_ok = ({1'b0, param_q[7:4]} < 5'(NUM_REGS)) && ({1'b0, param_q[3:0]} < 5'(REG_BYTES));

  assign waiting     = (state_q == ST_WAITPARAM) || (state_q == ST_WAITDATA);
  assign tmo_expired = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = tmo_q + 1'b1;
    if (rx_valid || !waiting || tmo_expired) begin
      tmo_d = '0;
    end
  end

  always_comb begin
    ovf_d = (ovf_q && !status_clr) || fifo_ovf;
  end

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    param_d    = param_q;
    sel_d      = sel_q;
    bcnt_d     = bcnt_q;
    regs_d     = regs_q;
    armed_d    = armed_q;
    rx_ovr_d   = rx_ovr_q;
    status_clr = 1'b0;
    push       = 1'b0;
    push_data  = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          case (rx_byte)
            CMD_PING: begin
              push      = 1'b1;
              push_data = RESP_ACK;
            end
            CMD_ARM: begin
              armed_d   = 1'b1;
              push      = 1'b1;
              push_data = RESP_ACK;
            end
            CMD_DISARM: begin
              armed_d   = 1'b0;
              push      = 1'b1;
              push_data = RESP_ACK;
            end
            CMD_STATUS: begin
              push       = 1'b1;
              push_data  = status_byte(armed_q, ovf_q, rx_ovr_q);
              status_clr = 1'b1;
              rx_ovr_d   = 1'b0;
            end
            CMD_READ, CMD_WRITE, CMD_READ_ALL: begin
              opcode_d = rx_byte;
              state_d  = ST_WAITPARAM;
            end
            default: begin
              push      = 1'b1;
              push_data = RESP_NACK;
            end
          endcase
        end
      end
      ST_WAITPARAM: begin
        if (rx_valid) begin
          if (opcode_q == CMD_READ_ALL) begin
            if (rx_byte < 8'(NUM_REGS)) begin
              sel_d   = rx_byte[RIW-1:0];
              bcnt_d  = '0;
              state_d = ST_STREAM;
            end else begin
              push      = 1'b1;
              push_data = RESP_NACK;
              state_d   = ST_IDLE;
            end
          end else begin
            param_d = rx_byte;
            state_d = ST_WAITDATA;
          end
        end else if (tmo_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAITDATA: begin
        if (rx_valid) begin
          state_d   = ST_IDLE;
          push      = 1'b1;
          push_data = RESP_NACK;
          if (opcode_q == CMD_READ) begin
            if (rd_ok) begin
              push_data = regs_q[param_q[RIW-1:0]][rx_byte[BIW-1:0]];
            end
          end else if (wr_ok) begin
            regs_d[param_q[4 +: RIW]][param_q[BIW-1:0]] = rx_byte;
            push_data = RESP_ACK;
          end
        end else if (tmo_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        // No writes can land while streaming, so reading live registers equals sampling at entry.
        push      = 1'b1;
        push_data = regs_q[sel_q][bcnt_q];
        if (bcnt_q == BIW'(REG_BYTES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
        if (rx_valid) begin
          rx_ovr_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      opcode_q <= '0;
      param_q  <= '0;
      sel_q    <= '0;
      bcnt_q   <= '0;
      tmo_q    <= '0;
      armed_q  <= 1'b0;
      ovf_q    <= 1'b0;
      rx_ovr_q <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
        for (int b = 0; b < REG_BYTES; b++) begin
          regs_q[r][b] <= '0;
        end
      end
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      param_q  <= param_d;
      sel_q    <= sel_d;
      bcnt_q   <= bcnt_d;
      tmo_q    <= tmo_d;
      armed_q  <= armed_d;
      ovf_q    <= ovf_d;
      rx_ovr_q <= rx_ovr_d;
      regs_q   <= regs_d;
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    for (genvar gj = 0; gj < REG_BYTES; gj++) begin : g_byte
      assign regs_flat[(gi*REG_BYTES + gj)*8 +: 8] = regs_q[gi][gj];
    end
  end

endmodule

// File: tb/tb_command_regfile.sv
// Randomised self-checking bench for command_regfile against a command-level
// model of the register bank, flags and response stream.
module tb_command_regfile;

  localparam int NR  = 4;
  localparam int RB  = 4;
  localparam int DEP = 8;
  localparam int TMO = 40;

  logic              clk;
  logic              rst;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              tx_ready;
  logic              tx_valid;
  logic [7:0]        tx_byte;
  logic              armed;
  logic [NR*RB*8-1:0] regs_flat;

  command_regfile #(
    .NUM_REGS       (NR),
    .REG_BYTES      (RB),
    .RESP_DEPTH     (DEP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_byte   (tx_byte),
    .armed     (armed),
    .regs_flat (regs_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] m_regs [NR][RB];
  logic       m_armed, m_ovf, m_rx_ovr;

  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) got_q.push_back(tx_byte);
  end

  function automatic void model_reset();
    for (int r = 0; r < NR; r++)
      for (int b = 0; b < RB; b++) m_regs[r][b] = 8'h00;
    m_armed = 0; m_ovf = 0; m_rx_ovr = 0;
    exp_q.delete();
  endfunction

  // Nothing drains while tx_ready is low, so the queue length is the FIFO occupancy.
  function automatic void m_push(input logic [7:0] b);
    if (!tx_ready && exp_q.size() >= DEP) m_ovf = 1'b1;
    else exp_q.push_back(b);
  endfunction

  function automatic void model_cmd(input logic [7:0] op, input logic [7:0] p, input logic [7:0] d);
    int r, b;
    case (op)
      8'h01: m_push(8'hAA);
      8'h04: begin m_armed = 1; m_push(8'hAA); end
      8'h05: begin m_armed = 0; m_push(8'hAA); end
      8'h07: begin
        m_push({m_armed, m_ovf, m_rx_ovr, 5'b0});
        m_ovf = 0; m_rx_ovr = 0;
      end
      8'h02: begin
        if (p < NR && d < RB) m_push(m_regs[p][d]);
        else m_push(8'hFF);
      end
      8'h03: begin
        r = p / 16; b = p % 16;
        if (r < NR && b < RB) begin m_regs[r][b] = d; m_push(8'hAA); end
        else m_push(8'hFF);
      end
      8'h06: begin
        if (p < NR) for (int i = 0; i < RB; i++) m_push(m_regs[p][i]);
        else m_push(8'hFF);
      end
      default: m_push(8'hFF);
    endcase
  endfunction

  function automatic logic [NR*RB*8-1:0] model_flat();
    logic [NR*RB*8-1:0] f;
    for (int r = 0; r < NR; r++)
      for (int b = 0; b < RB; b++) f[(r*RB + b)*8 +: 8] = m_regs[r][b];
    return f;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_byte = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [7:0] p, input logic [7:0] d);
    send_byte(op);
    if (op == 8'h02 || op == 8'h03 || op == 8'h06) send_byte(p);
    if (op == 8'h02 || op == 8'h03) send_byte(d);
    model_cmd(op, p, d);
  endtask

  task automatic wait_drain(output bit ok);
    int n = 0;
    while ((got_q.size() < exp_q.size() || tx_valid) && n < 300) begin
      @(posedge clk); n++;
    end
    repeat (3) @(posedge clk);
    #1;
    ok = (n < 300);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; tx_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid got %0b want 0", tx_valid); else n_pass++;
    n_checks++; if (tx_byte !== 8'h00) $display("FAIL reset_tx_byte got %02h want 00", tx_byte); else n_pass++;
    n_checks++; if (armed !== 1'b0) $display("FAIL reset_armed got %0b want 0", armed); else n_pass++;
    n_checks++; if (regs_flat !== model_flat()) $display("FAIL reset_regs got %h want %h", regs_flat, model_flat()); else n_pass++;
    rst = 1'b0;
    $display("reset: checked idle outputs");
  endtask

  task automatic test_ping_arm();
    bit ok;
    send_cmd(8'h01, 8'h00, 8'h00);
    wait_drain(ok);
    n_checks++; if (!ok || got_q.size() != exp_q.size()) $display("FAIL ping_count got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL ping_byte%0d got %02h want %02h", i, got_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (armed !== m_armed) $display("FAIL ping_armed got %0b want %0b", armed, m_armed); else n_pass++;
    $display("ping: %0d byte(s) out", got_q.size());
    got_q.delete(); exp_q.delete();
    send_cmd(8'h04, 8'h00, 8'h00);
    wait_drain(ok);
    n_checks++; if (!ok || got_q.size() != exp_q.size()) $display("FAIL arm_count got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL arm_byte%0d got %02h want %02h", i, got_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (armed !== m_armed) $display("FAIL arm_armed got %0b want %0b", armed, m_armed); else n_pass++;
    $display("arm: armed=%0b", armed);
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_write_read();
    bit ok;
    send_cmd(8'h03, 8'h12, 8'h5A);
    send_cmd(8'h02, 8'h01, 8'h02);
    wait_drain(ok);
    n_checks++; if (!ok || got_q.size() != exp_q.size()) $display("FAIL wr_rd_count got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL wr_rd_byte%0d got %02h want %02h", i, got_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (regs_flat[48 +: 8] !== 8'h5A) $display("FAIL wr_rd_slice got %02h want 5a", regs_flat[48 +: 8]); else n_pass++;
    n_checks++; if (regs_flat !== model_flat()) $display("FAIL wr_rd_regs got %h want %h", regs_flat, model_flat()); else n_pass++;
    $display("write/read: reg1 byte2 = %02h", regs_flat[48 +: 8]);
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_bad_index();
    bit ok;
    send_cmd(8'h03, 8'h40, 8'h11);
    send_cmd(8'h03, 8'h04, 8'h22);
    send_cmd(8'h02, 8'h00, 8'h04);
    send_cmd(8'h02, 8'h04, 8'h00);
    send_cmd(8'h06, 8'h04, 8'h00);
    send_cmd(8'h09, 8'h00, 8'h00);
    wait_drain(ok);
    n_checks++; if (!ok || got_q.size() != exp_q.size()) $display("FAIL bad_count got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL bad_byte%0d got %02h want %02h", i, got_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (regs_flat !== model_flat()) $display("FAIL bad_regs got %h want %h", regs_flat, model_flat()); else n_pass++;
    $display("bad index: %0d NACK(s)", got_q.size());
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_stream_hold();
    bit ok;
    logic [7:0] v;
    for (int i = 0; i < RB; i++) begin
      v = 8'(8'h11 * (i + 1));
      send_cmd(8'h03, 8'(8'h30 + i), v);
    end
    wait_drain(ok);
    got_q.delete(); exp_q.delete();
    tx_ready = 1'b0;
    send_cmd(8'h06, 8'h03, 8'h00);
    repeat (8) @(posedge clk);
    #1;
    n_checks++; if (tx_valid !== 1'b1 || got_q.size() != 0) $display("FAIL hold_valid got %0b/%0d want 1/0", tx_valid, got_q.size()); else n_pass++;
    tx_ready = 1'b1;
    wait_drain(ok);
    n_checks++; if (!ok || got_q.size() != exp_q.size()) $display("FAIL stream_count got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL stream_byte%0d got %02h want %02h", i, got_q[i], exp_q[i]); else n_pass++;
    end
    $display("stream reg3: %0d bytes", got_q.size());
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    bit ok;
    send_cmd(8'h05, 8'h00, 8'h00);
    tx_ready = 1'b0;
    for (int i = 0; i < DEP + 1; i++) send_cmd(8'h01, 8'h00, 8'h00);
    tx_ready = 1'b1;
    wait_drain(ok);
    send_cmd(8'h07, 8'h00, 8'h00);
    send_cmd(8'h07, 8'h00, 8'h00);
    wait_drain(ok);
    n_checks++; if (!ok || got_q.size() != exp_q.size()) $display("FAIL ovf_count got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL ovf_byte%0d got %02h want %02h", i, got_q[i], exp_q[i]); else n_pass++;
    end
    $display("overflow: %0d bytes incl status", got_q.size());
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    bit ok;
    @(posedge clk); #1; rx_valid = 1'b1; rx_byte = 8'h06;
    @(posedge clk); #1; rx_byte = 8'h00;
    @(posedge clk); #1; rx_byte = 8'h01;
    @(posedge clk); #1; rx_valid = 1'b0;
    model_cmd(8'h06, 8'h00, 8'h00);
    m_rx_ovr = 1'b1;
    wait_drain(ok);
    send_cmd(8'h07, 8'h00, 8'h00);
    wait_drain(ok);
    n_checks++; if (!ok || got_q.size() != exp_q.size()) $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL b2b_byte%0d got %02h want %02h", i, got_q[i], exp_q[i]); else n_pass++;
    end
    $display("back-to-back: %0d bytes", got_q.size());
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_timeout();
    bit ok;
    send_byte(8'h03);
    repeat (TMO + 2) @(posedge clk);
    send_cmd(8'h01, 8'h00, 8'h00);
    wait_drain(ok);
    n_checks++; if (!ok || got_q.size() != exp_q.size()) $display("FAIL timeout_count got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL timeout_byte%0d got %02h want %02h", i, got_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (regs_flat !== model_flat()) $display("FAIL timeout_regs got %h want %h", regs_flat, model_flat()); else n_pass++;
    $display("timeout: %0d byte(s) after abandoned write", got_q.size());
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] op, p, d;
    int r, b;
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 7))
        0: op = 8'h01;
        1: op = 8'h02;
        2: op = 8'h03;
        3: op = 8'h04;
        4: op = 8'h05;
        5: op = 8'h06;
        6: op = 8'h07;
        default: begin
          r = $urandom_range(0, 3);
          op = (r == 0) ? 8'h00 : (r == 1) ? 8'h08 : (r == 2) ? 8'h80 : 8'hFF;
        end
      endcase
      r = $urandom_range(0, 4);
      b = $urandom_range(0, 4);
      p = (op == 8'h03) ? {r[3:0], b[3:0]} : 8'(r);
      d = (op == 8'h03) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 4));
      send_cmd(op, p, d);
      wait_drain(ok);
      n_checks++; if (!ok || got_q.size() != exp_q.size()) $display("FAIL rand%0d_count got %0d want %0d", it, got_q.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL rand%0d_byte%0d got %02h want %02h", it, i, got_q[i], exp_q[i]); else n_pass++;
      end
      n_checks++; if (regs_flat !== model_flat()) $display("FAIL rand%0d_regs got %h want %h", it, regs_flat, model_flat()); else n_pass++;
      n_checks++; if (armed !== m_armed) $display("FAIL rand%0d_armed got %0b want %0b", it, armed, m_armed); else n_pass++;
      $display("rand %0d: op=%02h p=%02h d=%02h bytes=%0d", it, op, p, d, got_q.size());
      got_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_stream();
    bit ok;
    send_cmd(8'h04, 8'h00, 8'h00);
    wait_drain(ok);
    got_q.delete(); exp_q.delete();
    tx_ready = 1'b0;
    send_byte(8'h06);
    send_byte(8'h03);
    #3 rst = 1'b1;
    #1;
    model_reset();
    n_checks++; if (tx_valid !== 1'b0) $display("FAIL midrst_tx_valid got %0b want 0", tx_valid); else n_pass++;
    n_checks++; if (regs_flat !== model_flat()) $display("FAIL midrst_regs got %h want %h", regs_flat, model_flat()); else n_pass++;
    n_checks++; if (armed !== m_armed) $display("FAIL midrst_armed got %0b want %0b", armed, m_armed); else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tx_ready = 1'b1;
    got_q.delete();
    send_cmd(8'h01, 8'h00, 8'h00);
    wait_drain(ok);
    n_checks++; if (!ok || got_q.size() != exp_q.size()) $display("FAIL postrst_count got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL postrst_byte%0d got %02h want %02h", i, got_q[i], exp_q[i]); else n_pass++;
    end
    $display("reset mid-stream: %0d byte(s) after recovery", got_q.size());
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_ping_arm();
    test_write_read();
    test_bad_index();
    test_stream_hold();
    test_overflow();
    test_back_to_back();
    test_timeout();
    test_random();
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/command_regfile.md
Name: command_regfile

Overview:
- Parametrised successor to the UART command decoder. Parses 1–3 byte host commands and owns a bank of NUM_REGS glitch-timing registers, each REG_BYTES bytes wide.
- Queues response bytes in a show-ahead FIFO for the UART transmitter and drives the arm flag.
- Fully synchronous to clk. Input is byte strobes from the UART receiver; output is a valid/ready byte stream to the UART transmitter.

Parameters:
- NUM_REGS, 4, number of timing registers (1..16); index 0 clk-edges, 1 io-edges, 2 ns-edges, 3 pulse-width.
- REG_BYTES, 4, bytes per register (1..16).
- RESP_DEPTH, 8, response FIFO depth; power of two, must be >= REG_BYTES.
- TIMEOUT_CYCLES, 1000000, idle clocks after which a partial command is abandoned.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rx_valid  in  1  one-cycle strobe: rx_byte holds a new byte
- rx_byte  in  8  received byte
- tx_ready  in  1  transmitter can accept a byte
- tx_valid  out  1  response byte available
- tx_byte  out  8  FIFO head byte
- armed  out  1  glitch engine armed
- regs_flat  out  NUM_REGS*REG_BYTES*8  all registers concatenated; register k occupies bits [k*REG_BYTES*8 +: REG_BYTES*8]

Behaviour:
- Reset (asynchronous, active-high):
  - All registers 0, armed=0, FIFO empty, tx_valid=0, tx_byte=0.
  - Sticky flags 0, parser state IDLE, timeout counter 0.
- Parser states: IDLE, WAITPARAM, WAITDATA, STREAM.
- IDLE, on rx_valid, by opcode:
  - 0x01 PING → push 0xAA.
  - 0x04 ARM → armed=1, push 0xAA.
  - 0x05 DISARM → armed=0, push 0xAA.
  - 0x07 STATUS → push {armed, ovf, rx_ovr, 5'b0}, then clear ovf and rx_ovr.
  - 0x02 READ, 0x03 WRITE, 0x06 READ_ALL → latch opcode, go to WAITPARAM.
  - Any other opcode → push 0xFF.
- WAITPARAM, on rx_valid:
  - READ_ALL: param is a register index.
    - Index >= NUM_REGS → push 0xFF, go to IDLE.
    - Otherwise → go to STREAM.
  - READ/WRITE: latch param, go to WAITDATA.
- WAITDATA, on rx_valid (always returns to IDLE):
  - READ: param = register index, data = byte index. If both are in range, push that byte; else push 0xFF.
  - WRITE: param = {reg[7:4], byte[3:0]}, data = value. If both fields are in range, write the byte and push 0xAA; else no write, push 0xFF.
- STREAM:
  - Pushes REG_BYTES bytes of the selected register, byte 0 first, one per clock, then returns to IDLE.
  - Bytes are sampled at entry to STREAM; a coincident write cannot occur because rx is not accepted in this state.
  - rx_valid during STREAM: byte discarded, rx_ovr set.
- Response latency: a push is visible (tx_valid=1) the clock after the rx_valid cycle.
- Timeout: counter clears on every rx_valid. In WAITPARAM/WAITDATA, reaching TIMEOUT_CYCLES-1 returns the parser to IDLE with no response.
- FIFO handshake:
  - tx_valid = !empty; tx_byte = head.
  - Pop when tx_valid && tx_ready.
  - Simultaneous push and pop is allowed when full, with no loss.
  - Push when full and no pop → byte dropped, ovf set.
  - Pointers are log2(RESP_DEPTH)+1 bits wide with wrap-around.
- Register writes take effect on regs_flat the clock after the WAITDATA rx_valid. armed updates the clock after the opcode.
- Reset mid-command or mid-stream: everything returns to reset values; partially queued bytes are lost.

Decomposition:
- Shared package command_pkg holds:
  - opcode constants CMD_PING..CMD_STATUS;
  - RESP_ACK=0xAA, RESP_NACK=0xFF;
  - register index constants REG_CLKEDGES..REG_PULSEWIDTH;
  - parser state enum.
- One sub-module: resp_fifo (parametrised byte FIFO: show-ahead, full/empty, overflow pulse).

Test Plan:
- After reset send 0x01 → exactly one byte 0xAA out; armed stays 0. Then send 0x04 → armed=1, 0xAA out.
- WRITE 0x03,0x12,0x5A then READ 0x02,0x01,0x02 → ACK 0xAA, then 0x5A; regs_flat bits [32+16 +: 8] = 0x5A.
- WRITE 0x03,0x40,0x11 (reg 4 >= NUM_REGS) → 0xFF, no register change. READ with byte 4 → 0xFF.
- Load reg 3 = 0x44332211, hold tx_ready=0, send 0x06,0x03 → FIFO holds 11 22 33 44. Release tx_ready → bytes emerge in that order.
- Hold tx_ready=0 and send 9 PINGs → 8 queued, ovf set. Then STATUS → 0x40 (armed=0, ovf=1), with the ninth byte absent.
- Send 0x03 then wait TIMEOUT_CYCLES clocks, then 0x01 → single 0xAA (parser back in IDLE). Assert rst mid-STREAM → tx_valid=0 and all registers 0 immediately.
